wb_regfile: RTL and testbench

//  Write-back end of the EX->WB pipeline interface. Consumes the registered
//  ALU result, destination register and regWrite flag from the EX/WB stage.

---
 rtl/wb_regfile.sv | 59 +++++
 tb/tb_wb_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back register file: commits EX/WB results, serves two combinational
// read ports with same-cycle write-through bypass, and counts commits.
// Optional: define R0_ZERO_EN to hardwire register 0 to zero.
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_count;
  logic              w_commit;
  logic              w_byp_rs;
  logic              w_byp_rt;

`ifdef R0_ZERO_EN
  // Writes aimed at register 0 are dropped entirely: no storage, no bypass, no count.
  assign w_commit = wb_regWrite && (wb_rd != '0);
`else
  assign w_commit = wb_regWrite;
`endif

  assign w_byp_rs = reset && w_commit && (wb_rd == rs_addr);
  assign w_byp_rt = reset && w_commit && (wb_rd == rt_addr);

  // Register 0 is never written when R0_ZERO_EN is set, so it stays at its reset zero.
  assign rs_data  = !reset   ? '0 :
                    w_byp_rs ? wb_data : r_regs[rs_addr];
  assign rt_data  = !reset   ? '0 :
                    w_byp_rt ? wb_data : r_regs[rt_addr];
  assign wb_count = r_count;

  // NOTE: the storage array is reset on purpose -- decode must read 0 from every
  // register after reset, so this is flops, not an uninitialised RAM macro.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (w_commit) begin
      r_regs[wb_rd] <= wb_data;
      r_count       <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: randomized traffic against an array
// model, plus literal checks pinning reset, commit, bypass, hold, wrap and R0.
module tb_wb_regfile;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;
  localparam int NREGS  = 2**ADDR_W;
`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_regWrite;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [CNT_W-1:0]  wb_count;

  int checks   = 0;
  int failures = 0;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_regWrite (wb_regWrite),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_count    (wb_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an array of register values and a commit tally.
  logic [DATA_W-1:0] m_regs [NREGS];
  int unsigned       m_commits;

  function automatic bit model_commits();
    return wb_regWrite && !(R0_ZERO && wb_rd == 0);
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (!reset)                        return '0;
    if (R0_ZERO && a == 0)             return '0;
    if (model_commits() && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_commits = 0;
    end else if (model_commits()) begin
      m_regs[wb_rd] = wb_data;
      m_commits     = m_commits + 1;
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    check("rs_data", 32'(rs_data), 32'(model_read(rs_addr)));
    check("rt_data", 32'(rt_data), 32'(model_read(rt_addr)));
    check("wb_count", 32'(wb_count), 32'(m_commits % (2**CNT_W)));
  end

  task automatic drive(input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                       input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    wb_regWrite = we;
    wb_rd       = rd;
    wb_data     = d;
    rs_addr     = rs;
    rt_addr     = rt;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset held low while a write is presented
    reset = 1'b0;
    drive(1'b1, 3'd3, 8'hAA, 3'd3, 3'd3);
    tick(); tick();
    check("reset_rs", 32'(rs_data), 32'h0);
    check("reset_rt", 32'(rt_data), 32'h0);
    check("reset_cnt", 32'(wb_count), 32'h0);
    reset = 1'b1;
    drive(1'b0, 3'd3, 8'hAA, 3'd3, 3'd3);
    #1;
    check("reset_lost_wr", 32'(rs_data), 32'h0);
    tick();

    // 2: commit then read next cycle
    drive(1'b1, 3'd5, 8'h3C, 3'd1, 3'd1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd6);
    #1;
    check("commit_rd", 32'(rs_data), 32'h3C);
    check("commit_cnt", 32'(wb_count), 32'd1);
    tick();

    // 3: both read ports bypass the in-flight write
    drive(1'b1, 3'd2, 8'h71, 3'd2, 3'd2);
    #2;
    check("bypass_rs", 32'(rs_data), 32'h71);
    check("bypass_rt", 32'(rt_data), 32'h71);
    tick();

    // 4: disabled write leaves the entry and the count alone
    drive(1'b1, 3'd4, 8'h9A, 3'd0, 3'd0);
    tick();
    drive(1'b0, 3'd4, 8'hFF, 3'd4, 3'd4);
    #1;
    check("hold_bypass_off", 32'(rs_data), 32'h9A);
    tick();
    check("hold_reg", 32'(rt_data), 32'h9A);
    check("hold_cnt", 32'(wb_count), 32'd3);

    // 6: register 0 behaviour
    drive(1'b1, 3'd0, 8'h55, 3'd7, 3'd7);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    #1;
    check("r0_read", 32'(rs_data), R0_ZERO ? 32'h0 : 32'h55);
    check("r0_cnt", 32'(wb_count), R0_ZERO ? 32'd3 : 32'd4);
    tick();

    // Back-to-back rewrites of one index: last write wins
    drive(1'b1, 3'd6, 8'h11, 3'd6, 3'd1);
    tick();
    drive(1'b1, 3'd6, 8'h22, 3'd6, 3'd1);
    #1;
    check("rewrite_byp", 32'(rs_data), 32'h22);
    tick();
    drive(1'b0, 3'd6, 8'h00, 3'd6, 3'd6);
    #1;
    check("rewrite_last", 32'(rs_data), 32'h22);
    tick();

    // Randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), DATA_W'($urandom),
            ADDR_W'($urandom), ADDR_W'($urandom));
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      else                             reset = 1'b1;
      tick();
    end
    reset = 1'b1;

    // 5: counter wrap from all-ones to zero
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 2**CNT_W - 1; n++) begin
      drive(1'b1, ADDR_W'($urandom_range(1, NREGS - 1)), DATA_W'($urandom),
            ADDR_W'($urandom), ADDR_W'($urandom));
      tick();
    end
    check("cnt_allones", 32'(wb_count), 32'hFFFF);
    drive(1'b1, 3'd1, 8'h5A, 3'd1, 3'd2);
    tick();
    check("cnt_wrap", 32'(wb_count), 32'h0);
    drive(1'b0, 3'd1, 8'h00, 3'd1, 3'd1);
    tick();
    check("cnt_wrap_hold", 32'(wb_count), 32'h0);
    check("wrap_data", 32'(rs_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
